// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for serial_add_sub.
// The master side issues requests; the slave side is the arithmetic unit.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, mode, a, b, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, mode, a, b, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: DIGITS bits per clock, LSB first.
// The carry/borrow is chained through one register between slices.
module serial_add_sub #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_add_sub_if.slave bus
);

  localparam int N  = WIDTH / DIGITS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGITS < 1 || (WIDTH % DIGITS) != 0) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be >= 2 and divisible by DIGITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mode_q, mode_d;
  logic             chain_q, chain_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  logic [DIGITS-1:0] slice_sum;
  logic              slice_carry;
  logic              slice_carry_top;
  logic [WIDTH-1:0]  acc_shifted;
  logic              last_slice;

  // Operands shift right each slice, so the current slice always sits in the low DIGITS bits.
  always_comb begin
    logic c;
    c               = chain_q;
    slice_sum       = '0;
    slice_carry_top = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == DIGITS - 1) begin
        slice_carry_top = c;
      end
      slice_sum[i] = a_q[i] ^ b_q[i] ^ c;
      if (mode_q) begin
        c = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & c);
      end else begin
        c = (a_q[i] & b_q[i]) | ((a_q[i] ^ b_q[i]) & c);
      end
    end
    slice_carry = c;
  end

  assign acc_shifted = (acc_q >> DIGITS) | (WIDTH'(slice_sum) << (WIDTH - DIGITS));
  assign last_slice  = (k_q == KW'(N - 1));

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    chain_d    = chain_q;
    k_d        = k_q;
    acc_d      = acc_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          mode_d  = bus.mode;
          chain_d = bus.cin;
          k_d     = '0;
          acc_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        a_d     = a_q >> DIGITS;
        b_d     = b_q >> DIGITS;
        chain_d = slice_carry;
        acc_d   = acc_shifted;
        k_d     = k_q + KW'(1);
        // On the final slice the MSB of each original operand is in bit DIGITS-1.
        if (last_slice) begin
          state_d  = DONE;
          result_d = acc_shifted;
          cout_d   = slice_carry;
          if (mode_q) begin
            overflow_d = (a_q[DIGITS-1] ^ b_q[DIGITS-1]) &
                         (slice_sum[DIGITS-1] ^ a_q[DIGITS-1]);
          end else begin
            overflow_d = slice_carry_top ^ slice_carry;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mode_q     <= 1'b0;
      chain_q    <= 1'b0;
      k_q        <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      chain_q    <= chain_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: an 8-bit/1-digit instance for directed and handshake cases,
// and a 16-bit/4-digit instance streamed back-to-back with random operands.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_add_sub_if #(.WIDTH(8))  bus8 ();
  serial_add_sub_if #(.WIDTH(16)) bus16 ();

  serial_add_sub #(.WIDTH(8), .DIGITS(1)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  serial_add_sub #(.WIDTH(16), .DIGITS(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] prev8 = 8'h00;

  logic [15:0] opa [2000];
  logic [15:0] opb [2000];
  bit          opm [2000];
  bit          opc [2000];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void refModel(input int w, input bit m, input longint a, input longint b,
                                   input bit c, output longint res, output bit co, output bit ov);
    longint modv, half, sa, sb, full, sfull;
    modv  = 64'sd1 <<< w;
    half  = modv / 2;
    sa    = (a >= half) ? a - modv : a;
    sb    = (b >= half) ? b - modv : b;
    if (!m) begin
      full  = a + b + longint'(c);
      sfull = sa + sb + longint'(c);
      co    = (full >= modv);
    end else begin
      full  = a - b - longint'(c);
      sfull = sa - sb - longint'(c);
      co    = (full < 0);
    end
    res = ((full % modv) + modv) % modv;
    ov  = (sfull >= half) || (sfull < -half);
  endfunction

  task automatic applyStimulus(input bit m, input logic [7:0] a, input logic [7:0] b,
                               input bit c, input string tag);
    longint er;
    bit     ec, eo;
    int     cnt;
    refModel(8, m, longint'(a), longint'(b), c, er, ec, eo);
    @(negedge clk);
    bus8.mode  = m;
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = c;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = ~a;
    bus8.b     = ~b;
    bus8.mode  = ~m;
    cnt = 0;
    while (!bus8.done && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 4) begin
        checkOutput($sformatf("%s_busy", tag), 32'(bus8.busy), 32'd1);
        checkOutput($sformatf("%s_hold", tag), 32'(bus8.result), 32'(prev8));
      end
    end
    checkOutput($sformatf("%s_latency", tag), 32'(cnt), 32'd8);
    checkOutput($sformatf("%s_result", tag), 32'(bus8.result), 32'(er));
    checkOutput($sformatf("%s_cout", tag), 32'(bus8.cout), 32'(ec));
    checkOutput($sformatf("%s_ovf", tag), 32'(bus8.overflow), 32'(eo));
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s_pulse", tag), 32'(bus8.done), 32'd0);
    prev8 = 8'(er);
  endtask

  initial begin
    int     dones;
    logic [7:0] res_at_done;
    longint er;
    bit     ec, eo;
    int     cnt;

    rst         = 1'b1;
    bus8.start  = 1'b0;  bus8.mode  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
    bus16.start = 1'b0;  bus16.mode = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy8", 32'(bus8.busy), 32'd0);
    checkOutput("rst_done8", 32'(bus8.done), 32'd0);
    checkOutput("rst_result8", 32'(bus8.result), 32'd0);
    checkOutput("rst_cout8", 32'(bus8.cout), 32'd0);
    checkOutput("rst_ovf8", 32'(bus8.overflow), 32'd0);
    checkOutput("rst_busy16", 32'(bus16.busy), 32'd0);
    checkOutput("rst_result16", 32'(bus16.result), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b0, 8'd200, 8'd100, 1'b0, "add200_100");
    applyStimulus(1'b1, 8'd5,   8'd7,   1'b0, "sub5_7");
    applyStimulus(1'b1, 8'h80,  8'h01,  1'b0, "sub80_01");
    applyStimulus(1'b0, 8'h7F,  8'h01,  1'b0, "add7F_01");
    applyStimulus(1'b0, 8'hFF,  8'hFF,  1'b1, "addFF_FF_c");
    applyStimulus(1'b1, 8'h9C,  8'h00,  1'b0, "sub_b0");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i[0], 8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd8_%0d", i));
    end

    // A start pulse while busy must be ignored.
    @(negedge clk);
    bus8.mode = 1'b0; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus8.mode = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    dones = 0;
    res_at_done = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        dones++;
        res_at_done = bus8.result;
      end
    end
    checkOutput("ignore_start_dones", 32'(dones), 32'd1);
    checkOutput("ignore_start_result", 32'(res_at_done), 32'h47);

    // Reset during the fourth RUN cycle abandons the operation.
    @(negedge clk);
    bus8.mode = 1'b0; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("midrun_busy", 32'(bus8.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_busy", 32'(bus8.busy), 32'd0);
    checkOutput("midrst_done", 32'(bus8.done), 32'd0);
    checkOutput("midrst_result", 32'(bus8.result), 32'd0);
    checkOutput("midrst_cout", 32'(bus8.cout), 32'd0);
    checkOutput("midrst_ovf", 32'(bus8.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus8.done) dones++;
    end
    checkOutput("midrst_no_done", 32'(dones), 32'd0);
    prev8 = 8'h00;
    applyStimulus(1'b0, 8'h3C, 8'h4B, 1'b1, "after_rst");

    // Wide instance: start held high, operations stream back-to-back.
    for (int i = 0; i < 2000; i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
      opm[i] = (i >= 1000);
      opc[i] = 1'($urandom);
    end
    opa[0]    = 16'hFFFF; opb[0]    = 16'hFFFF; opc[0]    = 1'b1;
    opb[1000] = 16'h0000; opc[1000] = 1'b0;

    @(negedge clk);
    bus16.mode = opm[0]; bus16.a = opa[0]; bus16.b = opb[0]; bus16.cin = opc[0];
    bus16.start = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (i < 1999) begin
        bus16.mode = opm[i+1]; bus16.a = opa[i+1]; bus16.b = opb[i+1]; bus16.cin = opc[i+1];
      end else begin
        bus16.start = 1'b0;
      end
      cnt = 0;
      while (!bus16.done && cnt < 12) begin
        @(posedge clk);
        #1;
        cnt++;
      end
      refModel(16, opm[i], longint'(opa[i]), longint'(opb[i]), opc[i], er, ec, eo);
      checkOutput($sformatf("w16_period_%0d", i), 32'(cnt + 1), 32'd5);
      checkOutput($sformatf("w16_result_%0d", i), 32'(bus16.result), 32'(er));
      checkOutput($sformatf("w16_cout_%0d", i), 32'(bus16.cout), 32'(ec));
      checkOutput($sformatf("w16_ovf_%0d", i), 32'(bus16.overflow), 32'(eo));
      if (cnt >= 12) break;
      @(posedge clk);
      #1;
    end
    checkOutput("w16_idle_busy", 32'(bus16.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
